pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: priority stall vector, exception flush/redirect,
// stall and flush statistics, and a sticky stall watchdog.
module pipe_ctrl #(
  parameter int unsigned WDOG_LIMIT = 255,
  parameter logic [31:0] EXC_VEC    = 32'h0000_0040,
  parameter logic [31:0] INT_VEC    = 32'h0000_0020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count,
  output logic        wdog_trip
);

  // Watchdog width: at least 8 bits and enough to hold WDOG_LIMIT+1.
  localparam int             WD_RAW   = $clog2(WDOG_LIMIT + 2);
  localparam int             WD_W     = (WD_RAW < 8) ? 8 : WD_RAW;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(WDOG_LIMIT);
  localparam logic [WD_W-1:0] WD_MAX   = '1;

  typedef enum logic {
    RUN,
    FLUSHED
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     stall_cycles_q, stall_cycles_d;
  logic [15:0]     flush_count_q, flush_count_d;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            wdog_trip_q, wdog_trip_d;

  logic [5:0]      stall_req;
  logic            accept;
  logic            stalling;

  always_comb begin
    stall_req = 6'b000000;
    if (stallreq_mem)     stall_req = 6'b011111;
    else if (stallreq_ex) stall_req = 6'b001111;
    else if (stallreq_id) stall_req = 6'b000111;
    else if (stallreq_if) stall_req = 6'b000011;
  end

  always_comb begin
    accept   = !rst && (state_q == RUN) && (excepttype_i != 32'h0);
    flush    = accept;
    // An accepted exception (or reset) overrides every stall request.
    stall    = (rst || accept) ? 6'b000000 : stall_req;
    stalling = (stall != 6'b000000);

    new_pc = 32'h0;
    if (accept) begin
      case (excepttype_i)
        32'h0000_0001: new_pc = INT_VEC;
        32'h0000_000E: new_pc = cp0_epc_i;
        32'h0000_0008, 32'h0000_0009, 32'h0000_000A,
        32'h0000_000C, 32'h0000_000D: new_pc = EXC_VEC;
        default:       new_pc = EXC_VEC;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (accept) state_d = FLUSHED;
      FLUSHED: state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stalling) stall_cycles_d = stall_cycles_q + 32'd1;

    flush_count_d = flush_count_q;
    if (flush && (flush_count_q != 16'hFFFF)) flush_count_d = flush_count_q + 16'd1;

    wd_cnt_d = wd_cnt_q;
    if (!stalling || flush)    wd_cnt_d = '0;
    else if (wd_cnt_q != WD_MAX) wd_cnt_d = wd_cnt_q + 1'b1;

    wdog_trip_d = wdog_trip_q || (stalling && (wd_cnt_d >= WD_LIMIT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      stall_cycles_q <= 32'h0;
      flush_count_q  <= 16'h0;
      wd_cnt_q       <= '0;
      wdog_trip_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
      wd_cnt_q       <= wd_cnt_d;
      wdog_trip_q    <= wdog_trip_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
  assign wdog_trip    = wdog_trip_q;

endmodule
